// File: rtl/chip8_memory_fill.sv
// CHIP-8 memory: CPU read/write port, free-running video read port and a block-fill engine.
// Define CHIP8_MEM_WRITE_PROTECT_EN to suppress all writes below PROTECT_TOP (charset region).
module chip8_memory_fill #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 12,
    parameter int PROTECT_TOP = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_en,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_out,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done
);
    // state | meaning
    // IDLE  | CPU port owns memory, waiting for fill_start
    // FILL  | one fill word written per cycle, CPU port blocked
    // DONE  | single-cycle completion pulse, CPU port still blocked
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_fill_addr;
    logic [ADDR_W:0]   r_fill_cnt;
    logic [DATA_W-1:0] r_fill_value;
    logic [DATA_W-1:0] r_a_out;
    logic [DATA_W-1:0] r_b_out;

    logic              w_cpu_acc;
    logic              w_fill_load;
    logic              w_we;
    logic              w_prot;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_cpu_acc = a_en && (r_state == ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_fill_load  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (fill_start) begin
                    w_fill_load  = 1'b1;
                    w_state_next = (fill_len == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (r_fill_cnt == CNT_ONE) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The CPU can only write in IDLE and the engine only in FILL, so one write port suffices.
    always_comb begin
        w_waddr = a_addr;
        w_wdata = a_in;
        w_we    = w_cpu_acc && a_write;
        if (r_state == ST_FILL) begin
            w_waddr = r_fill_addr;
            w_wdata = r_fill_value;
            w_we    = 1'b1;
        end
    end

`ifdef CHIP8_MEM_WRITE_PROTECT_EN
    localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W+1)'(PROTECT_TOP);
    assign w_prot = ({1'b0, w_waddr} < PROT_LIM);
`else
    assign w_prot = 1'b0;
`endif

    // Reset blocks the write on its own edge so an aborted fill stops immediately.
    assign w_mem_we = w_we && !w_prot && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fill_addr  <= '0;
            r_fill_cnt   <= '0;
            r_fill_value <= '0;
            r_a_out      <= '0;
            r_b_out      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fill_load) begin
                r_fill_addr  <= fill_base;
                r_fill_cnt   <= fill_len;
                r_fill_value <= fill_value;
            end else if (r_state == ST_FILL) begin
                r_fill_addr <= r_fill_addr + ADDR_ONE;
                r_fill_cnt  <= r_fill_cnt - CNT_ONE;
            end
            if (w_cpu_acc) begin
                r_a_out <= r_mem[a_addr];
            end
            r_b_out <= r_mem[b_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign a_out     = r_a_out;
    assign b_out     = r_b_out;
    assign a_ready   = (r_state == ST_IDLE);
    assign fill_busy = (r_state == ST_FILL);
    assign fill_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_chip8_memory_fill.sv
// Directed bench for chip8_memory_fill: memory model plus read scoreboards for both ports.
// Follows CHIP8_MEM_WRITE_PROTECT_EN in the model when the macro is defined for the build.
module tb_chip8_memory_fill;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_en = 1'b0;
    logic        a_write = 1'b0;
    logic [11:0] a_addr = '0;
    logic [7:0]  a_in = '0;
    logic [7:0]  a_out;
    logic        a_ready;
    logic [11:0] b_addr = '0;
    logic [7:0]  b_out;
    logic        fill_start = 1'b0;
    logic [11:0] fill_base = '0;
    logic [12:0] fill_len = '0;
    logic [7:0]  fill_value = '0;
    logic        fill_busy;
    logic        fill_done;

    chip8_memory_fill dut (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_write(a_write), .a_addr(a_addr), .a_in(a_in),
        .a_out(a_out), .a_ready(a_ready),
        .b_addr(b_addr), .b_out(b_out),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         kn;
        logic [7:0] v;
    } exp_t;

    exp_t       aq[$];
    exp_t       bq[$];
    logic [7:0] m  [0:4095];
    bit         kn [0:4095];
    logic [7:0] ea = '0;
    bit         ea_kn = 1'b0;
    int         n_assert = 0;
    int         n_fail = 0;

    function automatic bit prot(input logic [11:0] a);
`ifdef CHIP8_MEM_WRITE_PROTECT_EN
        return a < 12'h200;
`else
        return (a === 12'hxxx);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: queue expected reads, apply the expected write to the model after the edge, check outputs.
    task automatic tick(input bit aread, input bit we, input logic [11:0] wa, input logic [7:0] wd,
                        input bit ebusy, input bit edone, input bit eready);
        exp_t e;
        if (aread) begin
            e.kn = kn[a_addr];
            e.v  = m[a_addr];
            aq.push_back(e);
        end
        e.kn = kn[b_addr];
        e.v  = m[b_addr];
        bq.push_back(e);
        @(posedge clk);
        if (we && !prot(wa)) begin
            m[wa]  = wd;
            kn[wa] = 1'b1;
        end
        #1;
        e = bq.pop_front();
        if (e.kn) chk("b_out", 32'(b_out), 32'(e.v));
        if (aread) begin
            e     = aq.pop_front();
            ea    = e.v;
            ea_kn = e.kn;
        end
        if (ea_kn) chk(aread ? "a_out" : "a_out_hold", 32'(a_out), 32'(ea));
        chk("fill_busy", 32'(fill_busy), 32'(ebusy));
        chk("fill_done", 32'(fill_done), 32'(edone));
        chk("a_ready", 32'(a_ready), 32'(eready));
    endtask

    task automatic rst_tick();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_en = 1'b0; a_write = 1'b0; fill_start = 1'b0;
        ea = '0; ea_kn = 1'b1;
        chk("rst_a_out", 32'(a_out), 32'h0);
        chk("rst_b_out", 32'(b_out), 32'h0);
        chk("rst_a_ready", 32'(a_ready), 32'h1);
        chk("rst_fill_busy", 32'(fill_busy), 32'h0);
        chk("rst_fill_done", 32'(fill_done), 32'h0);
    endtask

    task automatic rd(input logic [11:0] addr);
        a_en = 1'b1; a_write = 1'b0; a_addr = addr; b_addr = addr;
        tick(1'b1, 1'b0, addr, 8'h00, 1'b0, 1'b0, 1'b1);
        a_en = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [7:0] data);
        a_en = 1'b1; a_write = 1'b1; a_addr = addr; a_in = data; b_addr = addr;
        tick(1'b1, 1'b1, addr, data, 1'b0, 1'b0, 1'b1);
        a_en = 1'b0; a_write = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // cpu0: CPU access in the fill_start cycle; stray: ignored fill_start in FILL;
    // poke: CPU write to 0x400 every FILL cycle; rst_at: FILL cycle index that gets reset (-1 none).
    task automatic do_fill(input logic [11:0] base, input logic [12:0] len, input logic [7:0] val,
                           input bit cpu0, input bit cpu0_wr, input logic [11:0] cpu0_a,
                           input logic [7:0] cpu0_d, input bit stray, input bit poke, input int rst_at);
        logic [11:0] wa;
        fill_start = 1'b1; fill_base = base; fill_len = len; fill_value = val;
        a_en = cpu0; a_write = cpu0_wr; a_addr = cpu0_a; a_in = cpu0_d; b_addr = base;
        tick(cpu0, cpu0 && cpu0_wr, cpu0_a, cpu0_d, len != '0, len == '0, 1'b0);
        fill_start = 1'b0; a_en = 1'b0; a_write = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            wa = base + 12'(i);
            b_addr = wa;
            if (stray && i == 1) begin
                fill_start = 1'b1; fill_base = 12'h100; fill_len = 13'd3; fill_value = 8'hFF;
            end
            if (poke) begin
                a_en = 1'b1; a_write = 1'b1; a_addr = 12'h400; a_in = 8'h99;
            end
            if (i == rst_at) begin
                rst_tick();
                return;
            end
            tick(1'b0, 1'b1, wa, val, i < int'(len) - 1, i == int'(len) - 1, 1'b0);
            fill_start = 1'b0; a_en = 1'b0; a_write = 1'b0;
        end
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_tick();
        rst_tick();

        // Full-depth fill gives every writable word a known value.
        do_fill(12'h000, 13'h1000, 8'h5A, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, -1);

        wr(12'h300, 8'hA5);
        rd(12'h300);
        wr(12'h010, 8'h11);
        rd(12'h010);

        // Wrapping fill, concurrent CPU read on the start cycle, ignored restart.
        do_fill(12'hFFE, 13'd4, 8'h3C, 1'b1, 1'b0, 12'h300, 8'h00, 1'b1, 1'b0, -1);
        rd(12'hFFE);
        rd(12'hFFF);
        rd(12'h000);
        rd(12'h001);
        rd(12'h002);
        rd(12'h100);

        do_fill(12'h500, 13'd0, 8'hEE, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, -1);
        rd(12'h500);

        // CPU write into the start cycle completes before the fill begins.
        do_fill(12'h600, 13'd8, 8'h77, 1'b1, 1'b1, 12'h6FF, 8'h42, 1'b0, 1'b1, -1);
        rd(12'h400);
        rd(12'h600);
        rd(12'h607);
        rd(12'h608);
        rd(12'h6FF);

        do_fill(12'h200, 13'd16, 8'hC3, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 5);
        idle();
        idle();
        for (int i = 0; i < 16; i++) rd(12'h200 + 12'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
